bcpu_shared_mem_arbiter: RTL and testbench

//  Round-robin arbiter sharing one port of a shared data BRAM between NUM_PORTS BCPU16 cores.

---
 rtl/bcpu_shared_mem_pkg.sv | 20 ++
 rtl/bcpu_rr_arbiter.sv | 34 +++
 rtl/bcpu_shared_mem_arbiter.sv | 116 +++++++++++
 tb/tb_bcpu_shared_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcpu_shared_mem_pkg.sv
// Shared definitions for the BCPU16 shared-memory arbiter: index width helper
// and the read-return tag carried alongside each BRAM access.
package bcpu_shared_mem_pkg;

  // Width of a port index; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The tag is sized for the largest supported core count so one type serves every build
  localparam int MAX_PORTS = 8;
  localparam int IDX_W     = idx_width(MAX_PORTS);

  // Read-return tag: valid marks a load, idx names the core that owns the data
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } mem_tag_t;

endpackage

// File: rtl/bcpu_rr_arbiter.sv
// Combinational round-robin picker: first requesting core at or above ptr,
// wrapping around, reported as a one-hot grant plus its binary index.
module bcpu_rr_arbiter
  import bcpu_shared_mem_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [SEL_W-1:0]     grant_idx,
  output logic                 any_valid
);

  logic [SEL_W-1:0] cand;

  // Walk the ports in priority order starting at ptr and keep the first hit
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = SEL_W'((int'(ptr) + i) % NUM_PORTS);
      if (!any_valid && req[cand]) begin
        any_valid   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bcpu_shared_mem_arbiter.sv
// Round-robin arbiter sharing one registered BRAM port between several BCPU16
// cores. One access is issued per cycle; load data comes back to its owner
// through a two-stage tag pipe that tracks the BRAM read latency.
module bcpu_shared_mem_arbiter
  import bcpu_shared_mem_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             req_wren,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wrdata,
  output logic [NUM_PORTS-1:0]             ack,
  output logic [NUM_PORTS-1:0]             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             mem_en,
  output logic                             mem_wren,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wrdata,
  input  logic [DATA_WIDTH-1:0]            mem_rddata
);

  localparam int SEL_W = idx_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  grant;
  logic [SEL_W-1:0]      win_idx;
  logic                  win_any;
  logic [SEL_W-1:0]      ptr;
  logic                  win_wren;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wrdata;
  mem_tag_t              tag_s1;
  mem_tag_t              tag_s2;
  logic [NUM_PORTS-1:0]  rd_hit;

  // A core being acknowledged this cycle still holds REQ; mask it so it is not granted twice
  assign eligible = req & ~ack;

  bcpu_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W)
  ) u_rr (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (win_idx),
    .any_valid (win_any)
  );

  // One-hot AND-OR select of the winner's command so losing cores' fields never leak through
  always_comb begin
    win_wren   = 1'b0;
    win_addr   = '0;
    win_wrdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        win_wren   = req_wren[i];
        win_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wrdata = req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Decode the tag leaving the pipe into the per-core read-valid pattern
  always_comb begin
    rd_hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (tag_s2.valid && (tag_s2.idx == IDX_W'(i))) rd_hit[i] = 1'b1;
    end
  end

  // Issue registers: drive the BRAM port, pulse ACK and advance the pointer past the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack        <= '0;
      mem_en     <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_wrdata <= '0;
      ptr        <= '0;
    end else begin
      ack    <= grant;
      mem_en <= win_any;
      if (win_any) begin
        mem_wren   <= win_wren;
        mem_addr   <= win_addr;
        mem_wrdata <= win_wrdata;
        ptr        <= (win_idx == SEL_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        mem_wren <= 1'b0;
      end
    end
  end

  // Tag pipe follows each access through the BRAM; loads hand the returned word to their owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_s1   <= '0;
      tag_s2   <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      tag_s1.valid <= win_any && !win_wren;
      tag_s1.idx   <= IDX_W'(win_idx);
      tag_s2       <= tag_s1;
      rd_valid     <= rd_hit;
      if (tag_s2.valid) rd_data <= mem_rddata;
    end
  end

endmodule

// File: tb/tb_bcpu_shared_mem_arbiter.sv
// Directed testbench for bcpu_shared_mem_arbiter: a table of single-cycle
// arbitration vectors followed by hand-written multi-cycle sequences.
module tb_bcpu_shared_mem_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       req_wren;
  logic [3:0][9:0]  req_addr;
  logic [3:0][15:0] req_wrdata;
  logic [3:0]       ack;
  logic [3:0]       rd_valid;
  logic [15:0]      rd_data;
  logic             mem_en;
  logic             mem_wren;
  logic [9:0]       mem_addr;
  logic [15:0]      mem_wrdata;
  logic [15:0]      mem_rddata;

  logic [15:0]      bram [1024];

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wren;
    logic [3:0]  exp_ack;
    logic        exp_en;
    logic        exp_wren;
    logic [9:0]  exp_addr;
    logic [15:0] exp_wrdata;
  } vec_t;

  vec_t       vecs [11];
  logic [3:0] exp_seq [5];

  bcpu_shared_mem_arbiter #(
    .NUM_PORTS  (4),
    .DATA_WIDTH (16),
    .ADDR_WIDTH (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_wren   (req_wren),
    .req_addr   (req_addr),
    .req_wrdata (req_wrdata),
    .ack        (ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .mem_en     (mem_en),
    .mem_wren   (mem_wren),
    .mem_addr   (mem_addr),
    .mem_wrdata (mem_wrdata),
    .mem_rddata (mem_rddata)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: writes commit at the edge after the port cycle, read data appears the cycle after the port cycle
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wren) bram[mem_addr] <= mem_wrdata;
      else          mem_rddata     <= bram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w);
    req      = r;
    req_wren = w;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_wren   = '0;
    req_addr   = {10'h043, 10'h042, 10'h041, 10'h040};
    req_wrdata = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    mem_rddata = '0;

    // Expected port state after each vector's edge, starting from PTR=0 with no ACK outstanding
    vecs[0]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 10'h040, 16'hA000};
    vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'h040, 16'hA000};
    vecs[2]  = '{4'b0011, 4'b0010, 4'b0010, 1'b1, 1'b1, 10'h041, 16'hA001};
    vecs[3]  = '{4'b0011, 4'b0000, 4'b0001, 1'b1, 1'b0, 10'h040, 16'hA000};
    vecs[4]  = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 1'b0, 10'h043, 16'hA003};
    vecs[5]  = '{4'b1100, 4'b0000, 4'b0100, 1'b1, 1'b0, 10'h042, 16'hA002};
    vecs[6]  = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 1'b0, 10'h043, 16'hA003};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'h043, 16'hA003};
    vecs[8]  = '{4'b0110, 4'b0100, 4'b0010, 1'b1, 1'b0, 10'h041, 16'hA001};
    vecs[9]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 10'h042, 16'hA002};
    vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'h042, 16'hA002};

    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;

    #2;
    checkOutput("reset_state",
                {ack, rd_valid, mem_en, mem_wren, mem_addr, mem_wrdata, rd_data},
                {4'b0, 4'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0});
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].req, vecs[v].wren);
      tick();
      checkOutput($sformatf("vec%0d", v),
                  {ack, mem_en, mem_wren, mem_addr, mem_wrdata},
                  {vecs[v].exp_ack, vecs[v].exp_en, vecs[v].exp_wren, vecs[v].exp_addr, vecs[v].exp_wrdata});
    end

    $display("[TB] async reset mid-run");
    applyStimulus(4'b1111, 4'b0000);
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset",
                {ack, rd_valid, mem_en, mem_wren, mem_addr, mem_wrdata, rd_data},
                {4'b0, 4'b0, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0});
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0001, 4'b0000);
    tick();
    checkOutput("post_reset_ack", {ack, mem_en}, {4'b0001, 1'b1});
    applyStimulus(4'b0000, 4'b0000);
    tick();
    applyStimulus(4'b0011, 4'b0000);
    tick();
    checkOutput("ptr_after_reset", ack, 4'b0010);
    applyStimulus(4'b0000, 4'b0000);
    tick(); tick(); tick();

    $display("[TB] single load");
    req_addr[3]   = 10'h155;
    req_wrdata[3] = 16'hBEEF;
    applyStimulus(4'b1000, 4'b1000);
    tick();
    checkOutput("preload_store", {ack, mem_en, mem_wren, mem_addr, mem_wrdata},
                {4'b1000, 1'b1, 1'b1, 10'h155, 16'hBEEF});
    applyStimulus(4'b0000, 4'b0000);
    tick();
    req_addr[2] = 10'h155;
    applyStimulus(4'b0100, 4'b0000);
    tick();
    checkOutput("load_issue", {ack, mem_en, mem_wren, mem_addr}, {4'b0100, 1'b1, 1'b0, 10'h155});
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("load_t2", rd_valid, 4'b0000);
    tick();
    checkOutput("load_t3", {rd_valid, rd_data}, {4'b0100, 16'hBEEF});
    tick();
    checkOutput("load_t4", rd_valid, 4'b0000);

    $display("[TB] store then load");
    req_addr[0]   = 10'h00A;
    req_wrdata[0] = 16'h1234;
    applyStimulus(4'b0001, 4'b0001);
    tick();
    checkOutput("store_issue", {ack, mem_wren, mem_addr, mem_wrdata}, {4'b0001, 1'b1, 10'h00A, 16'h1234});
    applyStimulus(4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("store_no_rdv%0d", k), rd_valid, 4'b0000);
    end
    applyStimulus(4'b0001, 4'b0000);
    tick();
    checkOutput("reload_issue", {ack, mem_wren}, {4'b0001, 1'b0});
    applyStimulus(4'b0000, 4'b0000);
    tick(); tick();
    checkOutput("reload_data", {rd_valid, rd_data}, {4'b0001, 16'h1234});

    $display("[TB] full contention");
    doReset();
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("rotate%0d", k), {ack, mem_en}, {exp_seq[k], 1'b1});
    end
    applyStimulus(4'b0000, 4'b0000);
    tick(); tick(); tick();

    $display("[TB] masking of held request");
    doReset();
    applyStimulus(4'b0010, 4'b0000);
    tick();
    checkOutput("mask_grant", {ack, mem_en}, {4'b0010, 1'b1});
    tick();
    checkOutput("mask_gap", {ack, mem_en}, {4'b0000, 1'b0});
    tick();
    checkOutput("mask_regrant", {ack, mem_en}, {4'b0010, 1'b1});
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("mask_idle", {ack, mem_en}, {4'b0000, 1'b0});
    tick(); tick();

    $display("[TB] reset during read");
    doReset();
    req_addr[3]   = 10'h020;
    req_wrdata[3] = 16'h5A5A;
    applyStimulus(4'b1000, 4'b1000);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("rr_load_issue", {ack, mem_en, mem_wren}, {4'b1000, 1'b1, 1'b0});
    applyStimulus(4'b0000, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("rr_dropped%0d", k), rd_valid, 4'b0000);
    end
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("rr_reissue", ack, 4'b1000);
    applyStimulus(4'b0000, 4'b0000);
    tick(); tick();
    checkOutput("rr_reload_data", {rd_valid, rd_data}, {4'b1000, 16'h5A5A});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
